// File: rtl/secuenciador_semaforo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : secuenciador_semaforo                                        |
// | Description : Traffic-light / pedestrian sequencer driving an external     |
// |               seconds timer (seconds strobe, per-phase duration, restart). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module secuenciador_semaforo #(
  parameter int unsigned DIV           = 50000000,
  parameter logic [3:0]  T_VERDE       = 4'd8,
  parameter logic [3:0]  T_VERDE_CORTO = 4'd3,
  parameter logic [3:0]  T_AMARILLO    = 4'd2,
  parameter logic [3:0]  T_ROJO        = 4'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       boton_peaton,
  input  logic       tiempo_expiro,
  output logic [3:0] valor,
  output logic       iniciar_timer,
  output logic       segundero,
  output logic       luz_verde,
  output logic       luz_amarilla,
  output logic       luz_roja,
  output logic       peaton_cruza
);

  localparam int unsigned      c_cw       = $clog2(DIV);
  localparam logic [c_cw-1:0]  c_cnt_max  = c_cw'(DIV - 1);
  localparam logic [c_cw-1:0]  c_cnt_half = c_cw'(DIV / 2);

  typedef enum logic [1:0] {
    FASE_VERDE    = 2'd0,
    FASE_AMARILLO = 2'd1,
    FASE_ROJO     = 2'd2
  } fase_t;

  typedef enum logic {
    EST_CARGA = 1'b0,
    EST_CORRE = 1'b1
  } estado_t;

  fase_t           r_fase,   w_fase_n;
  estado_t         r_estado, w_estado_n;
  logic [c_cw-1:0] r_cnt,    w_cnt_n;
  logic [1:0]      r_guard,  w_guard_n;
  logic            r_sol,    w_sol_n;
  // Request captured when red starts; it is consumed by the next green load.
  logic            r_pend,   w_pend_n;
  logic [3:0]      r_valor,  w_valor_n;
  logic            w_avanza;
  logic            r_sync1, r_sync2;
  logic            r_iniciar, r_seg, r_luz_v, r_luz_a, r_luz_r, r_cruza;

  // Next-state logic: CARGA/CORRE handshake with the timer and phase rotation.
  always_comb begin
    w_fase_n   = r_fase;
    w_estado_n = r_estado;
    w_cnt_n    = r_cnt;
    w_guard_n  = r_guard;
    w_sol_n    = r_sol;
    w_pend_n   = r_pend;
    w_valor_n  = r_valor;
    w_avanza   = 1'b0;

    case (r_estado)
      EST_CARGA: begin
        w_estado_n = EST_CORRE;
        w_cnt_n    = '0;
        w_guard_n  = 2'd0;
      end
      EST_CORRE: begin
        w_cnt_n   = (r_cnt == c_cnt_max) ? '0 : r_cnt + c_cw'(1);
        w_guard_n = (r_guard == 2'd3) ? 2'd3 : r_guard + 2'd1;
        // The guard hides expiry left over from the previous phase until the
        // synchronizer has flushed it.
        if ((r_guard == 2'd3) && r_sync2) begin
          w_avanza   = 1'b1;
          w_estado_n = EST_CARGA;
          w_cnt_n    = '0;
          w_guard_n  = 2'd0;
          case (r_fase)
            FASE_VERDE:    w_fase_n = FASE_AMARILLO;
            FASE_AMARILLO: w_fase_n = FASE_ROJO;
            default:       w_fase_n = FASE_VERDE;
          endcase
        end
      end
      default: w_estado_n = EST_CARGA;
    endcase

    // Duration is loaded together with the entry into CARGA.
    if (w_avanza) begin
      case (w_fase_n)
        FASE_VERDE:    w_valor_n = r_pend ? T_VERDE_CORTO : T_VERDE;
        FASE_AMARILLO: w_valor_n = T_AMARILLO;
        default:       w_valor_n = T_ROJO;
      endcase
    end

    // Pedestrian request: clearing at red entry wins over a simultaneous press.
    if (w_avanza && (w_fase_n == FASE_ROJO)) begin
      w_pend_n = r_sol;
      w_sol_n  = 1'b0;
    end else if (boton_peaton && (r_fase != FASE_ROJO)) begin
      w_sol_n = 1'b1;
    end
    if (w_avanza && (w_fase_n == FASE_VERDE)) begin
      w_pend_n = 1'b0;
    end
  end

  // State, prescaler, guard and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fase   <= FASE_VERDE;
      r_estado <= EST_CARGA;
      r_cnt    <= '0;
      r_guard  <= 2'd0;
      r_sol    <= 1'b0;
      r_pend   <= 1'b0;
      r_valor  <= T_VERDE;
    end else begin
      r_fase   <= w_fase_n;
      r_estado <= w_estado_n;
      r_cnt    <= w_cnt_n;
      r_guard  <= w_guard_n;
      r_sol    <= w_sol_n;
      r_pend   <= w_pend_n;
      r_valor  <= w_valor_n;
    end
  end

  // Two-flop synchronizer for the asynchronous expiry flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= tiempo_expiro;
      r_sync2 <= r_sync1;
    end
  end

  // Registered outputs decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iniciar <= 1'b0;
      r_seg     <= 1'b0;
      r_luz_v   <= 1'b1;
      r_luz_a   <= 1'b0;
      r_luz_r   <= 1'b0;
      r_cruza   <= 1'b0;
    end else begin
      r_iniciar <= (w_estado_n == EST_CORRE);
      r_seg     <= (w_estado_n == EST_CORRE) && (w_cnt_n >= c_cnt_half);
      r_luz_v   <= (w_fase_n == FASE_VERDE);
      r_luz_a   <= (w_fase_n == FASE_AMARILLO);
      r_luz_r   <= (w_fase_n == FASE_ROJO);
      r_cruza   <= (w_fase_n == FASE_ROJO);
    end
  end

  assign valor         = r_valor;
  assign iniciar_timer = r_iniciar;
  assign segundero     = r_seg;
  assign luz_verde     = r_luz_v;
  assign luz_amarilla  = r_luz_a;
  assign luz_roja      = r_luz_r;
  assign peaton_cruza  = r_cruza;

endmodule
`default_nettype wire

// File: doc/secuenciador_semaforo.md
Name: secuenciador_semaforo

Overview:
- Initiator/client side of the seconds-timer interface. It generates the seconds strobe (segundero), loads the per-phase duration (valor), and restarts the timer through iniciar_timer. It consumes tiempo_expiro to advance a 3-phase traffic-light/pedestrian sequence.
- Sits between the board clock and the existing seconds timer. Drives the light outputs.

Parameters:
- DIV, 50000000, clk cycles per second; even and ≥4 (benches use 8).
- T_VERDE, 8, green duration in seconds (4-bit).
- T_VERDE_CORTO, 3, green duration in seconds when a pedestrian request is pending.
- T_AMARILLO, 2, yellow duration in seconds.
- T_ROJO, 5, red/pedestrian-cross duration in seconds.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- boton_peaton  in  1  pedestrian request, level, synchronous to clk.
- tiempo_expiro  in  1  timer expiry flag (count ≥ valor), asynchronous to this block.
- valor  out  4  duration for the current phase, in seconds.
- iniciar_timer  out  1  0 clears the timer count; 1 lets it run.
- segundero  out  1  seconds strobe; the timer counts on its falling edge.
- luz_verde, luz_amarilla, luz_roja  out  1 each  one-hot lights.
- peaton_cruza  out  1  high during ROJO.

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0):
  - fase=VERDE, estado=CARGA, prescaler cnt=0, guard=0, solicitud=0, sync flops=0.
  - Outputs: valor=T_VERDE, iniciar_timer=0, segundero=0, luz_verde=1, luz_amarilla=0, luz_roja=0, peaton_cruza=0.
  - Reset mid-phase aborts the phase immediately. The sequence restarts at VERDE CARGA.
- Phases cycle VERDE -> AMARILLO -> ROJO -> VERDE. Lights are one-hot from fase. peaton_cruza = (fase==ROJO).
- estado CARGA (1 cycle):
  - iniciar_timer=0 and cnt=0.
  - valor = T_VERDE_CORTO if fase==VERDE and solicitud=1; T_VERDE for VERDE otherwise; T_AMARILLO for AMARILLO; T_ROJO for ROJO.
  - Next cycle: CORRE.
- estado CORRE:
  - iniciar_timer=1. valor is held constant.
  - cnt increments mod DIV. segundero = (cnt ≥ DIV/2), so the falling edge occurs on the wrap DIV-1 -> 0, one per DIV cycles.
  - guard counts 0..3 and saturates.
  - tiempo_expiro passes through a 2-flop synchronizer.
  - Advance condition: guard==3 and synchronized expiro==1. On advance: fase advances and estado returns to CARGA.
- Phase timing:
  - valor=N≥1: CORRE lasts N*DIV+3 cycles, with ±1 tolerance for async capture. Total phase length is N*DIV+4.
  - valor=0: the timer reports expiry at once, so CORRE lasts 4 cycles (±1). The guard prevents same-cycle re-advance.
- segundero is 0 in CARGA, so no spurious falling edge is generated by the restart.
- Pedestrian request:
  - solicitud is set on any cycle with boton_peaton=1 and fase≠ROJO.
  - It is cleared on entry to ROJO (the CARGA with fase==ROJO). A clear in the same cycle as a set takes priority.
  - Presses during ROJO are ignored.
  - A request raised during VERDE CORRE does not change the running valor; it takes effect on the next VERDE.
- Widths:
  - cnt is ceil(log2(DIV)) bits.
  - The duration parameters are 4-bit, so 15 s is the maximum and there is no wrap handling.

Test Plan:
- Reset then run with DIV=8, no button, bench timer model -> VERDE lasts 8*8+4=68 cycles (±1), AMARILLO 20, ROJO 44, then VERDE repeats; lights one-hot throughout.
- boton_peaton pulsed 1 cycle during AMARILLO -> next ROJO shows peaton_cruza=1; solicitud cleared; following VERDE uses valor=3 (28 cycles).
- boton_peaton held during ROJO only -> no request latched; next VERDE uses valor=8.
- T_AMARILLO=0 -> AMARILLO phase is 5 cycles (±1); no double advance; ROJO follows normally.
- rst_n asserted mid-ROJO, async between clk edges -> outputs return immediately to reset values; after release, VERDE CARGA on the first clk edge.
- Check every CARGA -> iniciar_timer=0 for exactly 1 cycle, segundero=0, valor stable through the following CORRE, and exactly N segundero falling edges before the advance.
